// File: rtl/cmdif_pkg.sv
// Shared definitions for the command interface: opcodes, issuer state encoding and
// the keep-mask popcount used for response byte accounting.
package cmdif_pkg;

    localparam logic [7:0] OpReadData  = 8'h00;
    localparam logic [7:0] OpClkSwitch = 8'h01;
    localparam logic [7:0] OpVersion   = 8'h02;
    localparam logic [7:0] OpSpi       = 8'h03;
    localparam logic [7:0] OpFifoUsed  = 8'h04;
    localparam logic [7:0] OpSetLength = 8'h05;
    localparam logic [7:0] OpPhaseStep = 8'h06;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSend    = 2'd1,
        StWaitRsp = 2'd2,
        StDone    = 2'd3
    } state_e;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

endpackage

// File: rtl/cmd_issuer.sv
// Issues an 8-byte command over a byte stream, then optionally collects a 32-bit
// response stream with byte accounting and an idle timeout.
module cmd_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_data,
    input  logic        cmd_expect_rsp,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic [7:0]  o_tdata,
    input  logic        i_tvalid,
    output logic        i_tready,
    input  logic [31:0] i_tdata,
    input  logic [3:0]  i_tkeep,
    input  logic        i_tlast,
    output logic        rsp_word_valid,
    output logic [31:0] rsp_word,
    output logic [3:0]  rsp_keep,
    output logic [15:0] rsp_bytes,
    output logic        rsp_timeout,
    output logic        done
);
    import cmdif_pkg::*;

    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [63:0] data_q, data_d;
    logic        expect_q, expect_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] timer_q, timer_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  keep_q, keep_d;
    logic [15:0] bytes_q, bytes_d;
    logic        timeout_q, timeout_d;
    logic [16:0] bytes_sum;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        expect_d     = expect_q;
        idx_d        = idx_q;
        timer_d      = timer_q;
        word_valid_d = 1'b0;
        word_d       = word_q;
        keep_d       = keep_q;
        bytes_d      = bytes_q;
        timeout_d    = timeout_q;
        bytes_sum    = {1'b0, bytes_q} + {14'b0, popcount4(i_tkeep)};

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    data_d    = cmd_data;
                    expect_d  = cmd_expect_rsp;
                    bytes_d   = 16'h0000;
                    timeout_d = 1'b0;
                    idx_d     = 3'd0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (o_tready) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        timer_d = 16'h0000;
                        state_d = expect_q ? StWaitRsp : StDone;
                    end
                end
            end
            StWaitRsp: begin
                // A beat always beats the timeout, even on the expiring cycle.
                if (i_tvalid) begin
                    timer_d = 16'h0000;
                    bytes_d = bytes_sum[16] ? 16'hFFFF : bytes_sum[15:0];
                    if (i_tkeep != 4'h0) begin
                        word_valid_d = 1'b1;
                        word_d       = i_tdata;
                        keep_d       = i_tkeep;
                    end
                    if (i_tlast) begin
                        state_d = StDone;
                    end
                end else if (timer_q == TimeoutLast) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            data_q       <= 64'h0;
            expect_q     <= 1'b0;
            idx_q        <= 3'd0;
            timer_q      <= 16'h0000;
            word_valid_q <= 1'b0;
            word_q       <= 32'h0;
            keep_q       <= 4'h0;
            bytes_q      <= 16'h0000;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            expect_q     <= expect_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            word_valid_q <= word_valid_d;
            word_q       <= word_d;
            keep_q       <= keep_d;
            bytes_q      <= bytes_d;
            timeout_q    <= timeout_d;
        end
    end

    assign cmd_ready      = (state_q == StIdle);
    assign o_tvalid       = (state_q == StSend);
    assign o_tdata        = (state_q == StSend) ? data_q[{idx_q, 3'b000} +: 8] : 8'h00;
    assign i_tready       = (state_q == StWaitRsp);
    assign done           = (state_q == StDone);
    assign rsp_word_valid = word_valid_q;
    assign rsp_word       = word_q;
    assign rsp_keep       = keep_q;
    assign rsp_bytes      = bytes_q;
    assign rsp_timeout    = timeout_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer: reset, version/read transactions, backpressure,
// no-response commands, timeout paths and reset abandoning a command.
module tb_cmd_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] cmd_data;
    logic        cmd_expect_rsp;
    logic        o_tvalid;
    logic        o_tready;
    logic [7:0]  o_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] i_tdata;
    logic [3:0]  i_tkeep;
    logic        i_tlast;
    logic        rsp_word_valid;
    logic [31:0] rsp_word;
    logic [3:0]  rsp_keep;
    logic [15:0] rsp_bytes;
    logic        rsp_timeout;
    logic        done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    cmd_issuer #(.TIMEOUT_CYCLES(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .cmd_expect_rsp (cmd_expect_rsp),
        .o_tvalid       (o_tvalid),
        .o_tready       (o_tready),
        .o_tdata        (o_tdata),
        .i_tvalid       (i_tvalid),
        .i_tready       (i_tready),
        .i_tdata        (i_tdata),
        .i_tkeep        (i_tkeep),
        .i_tlast        (i_tlast),
        .rsp_word_valid (rsp_word_valid),
        .rsp_word       (rsp_word),
        .rsp_keep       (rsp_keep),
        .rsp_bytes      (rsp_bytes),
        .rsp_timeout    (rsp_timeout),
        .done           (done)
    );

    // Advance one cycle; outputs are observed and inputs driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a command for one cycle; returns in the first SEND cycle.
    task automatic issue(input logic [63:0] data, input logic exp_rsp);
        cmd_valid      = 1'b1;
        cmd_data       = data;
        cmd_expect_rsp = exp_rsp;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({cmd_ready, o_tvalid, i_tready, done, rsp_word_valid, rsp_timeout} !== 6'b100000)
            $display("FAIL reset_flags got rdy=%b ov=%b ir=%b done=%b wv=%b to=%b want 1,0,0,0,0,0",
                     cmd_ready, o_tvalid, i_tready, done, rsp_word_valid, rsp_timeout);
        else passed++;
        checks++;
        if (rsp_bytes !== 16'h0 || rsp_word !== 32'h0 || rsp_keep !== 4'h0 || o_tdata !== 8'h0)
            $display("FAIL reset_data got bytes=%h word=%h keep=%h tdata=%h want all 0",
                     rsp_bytes, rsp_word, rsp_keep, o_tdata);
        else passed++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_version();
        logic [7:0] exp_b;
        o_tready = 1'b1;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL version_ready got %b want 1", cmd_ready);
        else passed++;
        issue(64'h02, 1'b1);
        for (int k = 0; k < 8; k++) begin
            exp_b = (k == 0) ? 8'h02 : 8'h00;
            checks++;
            if (o_tvalid !== 1'b1 || o_tdata !== exp_b)
                $display("FAIL version_byte%0d got v=%b d=%h want v=1 d=%h", k, o_tvalid, o_tdata, exp_b);
            else passed++;
            tick();
        end
        checks++;
        if (i_tready !== 1'b1 || cmd_ready !== 1'b0 || o_tvalid !== 1'b0)
            $display("FAIL version_wait got ir=%b rdy=%b ov=%b want 1,0,0", i_tready, cmd_ready, o_tvalid);
        else passed++;
        i_tvalid = 1'b1; i_tdata = 32'h4; i_tkeep = 4'hF; i_tlast = 1'b1;
        tick();
        i_tvalid = 1'b0; i_tlast = 1'b0;
        checks++;
        if (rsp_word_valid !== 1'b1 || rsp_word !== 32'h4 || rsp_keep !== 4'hF)
            $display("FAIL version_word got wv=%b w=%h k=%h want 1 00000004 f", rsp_word_valid, rsp_word, rsp_keep);
        else passed++;
        checks++;
        if (rsp_bytes !== 16'd4 || done !== 1'b1 || rsp_timeout !== 1'b0)
            $display("FAIL version_done got bytes=%0d done=%b to=%b want 4,1,0", rsp_bytes, done, rsp_timeout);
        else passed++;
        tick();
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || rsp_bytes !== 16'd4 || rsp_word !== 32'h4)
            $display("FAIL version_hold got done=%b rdy=%b bytes=%0d w=%h want 0,1,4,00000004",
                     done, cmd_ready, rsp_bytes, rsp_word);
        else passed++;
    endtask

    task automatic test_read();
        logic [31:0] words [3];
        logic [3:0]  keeps [3];
        logic [15:0] exp_bytes [3];
        words = '{32'h11223344, 32'h55667788, 32'h000099AA};
        keeps = '{4'hF, 4'hF, 4'h3};
        exp_bytes = '{16'd4, 16'd8, 16'd10};
        o_tready = 1'b1;
        issue(64'h0000_000A_0000_0000, 1'b1);
        for (int k = 0; k < 8; k++) begin
            if (k == 4) begin
                checks++;
                if (o_tdata !== 8'h0A) $display("FAIL read_byte4 got %h want 0a", o_tdata);
                else passed++;
            end
            tick();
        end
        for (int b = 0; b < 3; b++) begin
            i_tvalid = 1'b1; i_tdata = words[b]; i_tkeep = keeps[b]; i_tlast = (b == 2);
            tick();
            checks++;
            if (rsp_word_valid !== 1'b1 || rsp_word !== words[b] || rsp_keep !== keeps[b]
                || rsp_bytes !== exp_bytes[b] || done !== (b == 2))
                $display("FAIL read_beat%0d got wv=%b w=%h k=%h bytes=%0d done=%b want 1 %h %h %0d %b",
                         b, rsp_word_valid, rsp_word, rsp_keep, rsp_bytes, done,
                         words[b], keeps[b], exp_bytes[b], (b == 2));
            else passed++;
        end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        tick();
        checks++;
        if (rsp_word_valid !== 1'b0 || done !== 1'b0 || rsp_bytes !== 16'd10)
            $display("FAIL read_after got wv=%b done=%b bytes=%0d want 0,0,10", rsp_word_valid, done, rsp_bytes);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [63:0] c;
        int          bad;
        c   = 64'h8877_6655_4433_2211;
        bad = 0;
        o_tready = 1'b0;
        issue(c, 1'b0);
        // Cycle c: ready low on even, high on odd; each byte is seen in both.
        for (int cyc = 0; cyc < 16; cyc++) begin
            o_tready = cyc[0];
            if (o_tvalid !== 1'b1 || o_tdata !== c[8 * (cyc / 2) +: 8]) begin
                bad++;
                $display("FAIL bp_cycle%0d got v=%b d=%h want v=1 d=%h", cyc, o_tvalid, o_tdata,
                         c[8 * (cyc / 2) +: 8]);
            end
            tick();
        end
        o_tready = 1'b1;
        checks++;
        if (bad != 0) $display("FAIL bp_stream got %0d bad cycles want 0", bad);
        else passed++;
        checks++;
        if (done !== 1'b1 || o_tvalid !== 1'b0)
            $display("FAIL bp_done got done=%b ov=%b want 1,0", done, o_tvalid);
        else passed++;
        tick();
    endtask

    task automatic test_no_rsp();
        int ir_seen;
        ir_seen = 0;
        o_tready = 1'b1;
        issue(64'h0000_0000_0000_1205, 1'b0);
        for (int k = 0; k < 8; k++) begin
            if (i_tready) ir_seen++;
            tick();
        end
        checks++;
        if (done !== 1'b1 || i_tready !== 1'b0 || rsp_bytes !== 16'd0 || ir_seen != 0)
            $display("FAIL norsp_done got done=%b ir=%b bytes=%0d ir_seen=%0d want 1,0,0,0",
                     done, i_tready, rsp_bytes, ir_seen);
        else passed++;
        tick();
    endtask

    task automatic test_timeout();
        int early;
        early = 0;
        o_tready = 1'b1;
        issue(64'h03, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 16; k++) begin
            if (done || !i_tready) early++;
            tick();
        end
        checks++;
        if (early != 0) $display("FAIL timeout_early got %0d bad cycles want 0", early);
        else passed++;
        checks++;
        if (done !== 1'b1 || rsp_timeout !== 1'b1 || rsp_bytes !== 16'd0)
            $display("FAIL timeout_done got done=%b to=%b bytes=%0d want 1,1,0", done, rsp_timeout, rsp_bytes);
        else passed++;
        tick();
        checks++;
        if (rsp_timeout !== 1'b1 || cmd_ready !== 1'b1)
            $display("FAIL timeout_hold got to=%b rdy=%b want 1,1", rsp_timeout, cmd_ready);
        else passed++;
    endtask

    task automatic test_beat_vs_timeout();
        int early;
        early = 0;
        o_tready = 1'b1;
        issue(64'h06, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        for (int k = 0; k < 15; k++) tick();
        // Beat lands on the cycle the timer would otherwise expire.
        i_tvalid = 1'b1; i_tdata = 32'hDEAD_BEEF; i_tkeep = 4'h1; i_tlast = 1'b0;
        tick();
        i_tvalid = 1'b0;
        checks++;
        if (done !== 1'b0 || rsp_word_valid !== 1'b1 || rsp_bytes !== 16'd1 || rsp_timeout !== 1'b0)
            $display("FAIL race_beat got done=%b wv=%b bytes=%0d to=%b want 0,1,1,0",
                     done, rsp_word_valid, rsp_bytes, rsp_timeout);
        else passed++;
        for (int k = 0; k < 16; k++) begin
            if (done) early++;
            tick();
        end
        checks++;
        if (early != 0 || done !== 1'b1 || rsp_timeout !== 1'b1 || rsp_bytes !== 16'd1)
            $display("FAIL race_timeout got early=%0d done=%b to=%b bytes=%0d want 0,1,1,1",
                     early, done, rsp_timeout, rsp_bytes);
        else passed++;
        tick();
    endtask

    task automatic test_keep0_last();
        o_tready = 1'b1;
        issue(64'h04, 1'b1);
        for (int k = 0; k < 8; k++) tick();
        i_tvalid = 1'b1; i_tdata = 32'h1234_5678; i_tkeep = 4'h0; i_tlast = 1'b1;
        tick();
        i_tvalid = 1'b0; i_tlast = 1'b0;
        checks++;
        if (done !== 1'b1 || rsp_word_valid !== 1'b0 || rsp_bytes !== 16'd0 || rsp_timeout !== 1'b0)
            $display("FAIL keep0_done got done=%b wv=%b bytes=%0d to=%b want 1,0,0,0",
                     done, rsp_word_valid, rsp_bytes, rsp_timeout);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid();
        int stray;
        stray = 0;
        o_tready = 1'b1;
        issue(64'h0706_0504_0302_0100, 1'b1);
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (o_tdata !== 8'h04) $display("FAIL rstmid_byte4 got %h want 04", o_tdata);
        else passed++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (o_tvalid !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0)
            $display("FAIL rstmid_idle got ov=%b rdy=%b done=%b want 0,1,0", o_tvalid, cmd_ready, done);
        else passed++;
        for (int k = 0; k < 20; k++) begin
            if (done || i_tready || o_tvalid) stray++;
            tick();
        end
        checks++;
        if (stray != 0) $display("FAIL rstmid_quiet got %0d active cycles want 0", stray);
        else passed++;
    endtask

    initial begin
        rst            = 1'b1;
        cmd_valid      = 1'b0;
        cmd_data       = 64'h0;
        cmd_expect_rsp = 1'b0;
        o_tready       = 1'b0;
        i_tvalid       = 1'b0;
        i_tdata        = 32'h0;
        i_tkeep        = 4'h0;
        i_tlast        = 1'b0;

        test_reset();
        test_version();
        test_read();
        test_backpressure();
        test_no_rsp();
        test_timeout();
        test_beat_vs_timeout();
        test_keep0_last();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning idle cycles allowed in WAIT_RSP before abort (range 1..65535).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all logic on its rising edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid&cmd_ready.
- cmd_data  in  64  byte k = bits 8k+7:8k; byte 0 = opcode.
- cmd_expect_rsp  in  1  1 = command produces a response stream.
- o_tvalid  out  1  byte-stream master valid.
- o_tready  in  1  byte-stream master ready.
- o_tdata  out  8  command byte.
- i_tvalid  in  1  response-stream slave valid.
- i_tready  out  1  response-stream slave ready.
- i_tdata  in  32  response word.
- i_tkeep  in  4  valid-byte mask, contiguous from bit 0.
- i_tlast  in  1  final response word.
- rsp_word_valid  out  1  one-cycle pulse, rsp_word/rsp_keep valid.
- rsp_word  out  32  captured response word.
- rsp_keep  out  4  captured tkeep.
- rsp_bytes  out  16  response bytes counted for current command.
- rsp_timeout  out  1  last command aborted by timeout.
- done  out  1  one-cycle pulse, command complete.

Function
REQ-003 SHALL implement states IDLE, SEND, WAIT_RSP, DONE.
REQ-004 IDLE: cmd_ready=1; on cmd_valid, SHALL latch cmd_data and cmd_expect_rsp, clear rsp_bytes and rsp_timeout, set byte index 0, go SEND.
REQ-005 SEND: o_tvalid=1, o_tdata=latched byte[index], byte 0 first; o_tvalid/o_tdata SHALL stay stable until o_tready.
REQ-006 On o_tready in SEND, index SHALL increment; after byte 7 accepted, go WAIT_RSP if expect flag set, else DONE.
REQ-007 Command accepted in cycle N SHALL put byte 0 on o_tdata in cycle N+1; with o_tready held 1, byte 7 in cycle N+8.
REQ-008 i_tready SHALL be 1 only in WAIT_RSP; i_tvalid elsewhere is ignored.
REQ-009 Each WAIT_RSP beat with i_tkeep!=0 SHALL drive rsp_word_valid=1, rsp_word=i_tdata, rsp_keep=i_tkeep in the next cycle.
REQ-010 Beats with i_tkeep=0 SHALL NOT pulse rsp_word_valid but SHALL be consumed and honour i_tlast.
REQ-011 rsp_bytes SHALL add popcount(i_tkeep) per beat, saturating at 16'hFFFF.
REQ-012 Beat with i_tlast=1 SHALL move to DONE next cycle.
REQ-013 16-bit idle timer SHALL clear on WAIT_RSP entry and on every beat, else increment; when it equals TIMEOUT_CYCLES-1 with no beat, SHALL set rsp_timeout=1 and go DONE.
REQ-014 Beat and timeout in same cycle: beat wins, timer clears.
REQ-015 DONE: done=1 for exactly one cycle, then IDLE; cmd_ready=0 in SEND, WAIT_RSP, DONE.
REQ-016 rsp_bytes, rsp_timeout, rsp_word, rsp_keep SHALL hold until the next command is accepted.

Reset
REQ-017 rst SHALL force IDLE and clear all outputs except cmd_ready, which is 1 in IDLE (i.e. cmd_ready=1, all other outputs 0, internal counters 0) at the same edge.
REQ-018 rst mid-SEND or mid-WAIT_RSP SHALL abandon the command with no done pulse.

Structure
REQ-019 Shared package cmdif_pkg SHALL hold opcode constants (0 read data, 1 clock switch, 2 version, 3 SPI, 4 FIFO used, 5 set length, 6 phase step), state encoding, and popcount4 function.
REQ-020 Single module, no sub-module.

Verification
REQ-021 Version: cmd_data=64'h02, expect=1, o_tready=1 -> bytes 02,00x7 in 8 cycles; reply 32'h4 keep F last -> rsp_word=4, rsp_bytes=4, done, rsp_timeout=0.
REQ-022 Read: opcode 0, byte4=0x0A -> reply keep F,F,3 last on 3rd -> three rsp_word_valid pulses, rsp_bytes=10.
REQ-023 Backpressure: o_tready 1,0 alternating -> each byte stable while low, byte 7 accepted 16 cycles after first offer.
REQ-024 No-response: opcode 5, expect=0 -> done the cycle after byte 7 accepted, i_tready never 1, rsp_bytes=0.
REQ-025 Timeout: TIMEOUT_CYCLES=16, expect=1, no reply -> done with rsp_timeout=1, 16 cycles after WAIT_RSP entry; keep-0 last beat instead -> done, rsp_bytes=0, no rsp_word_valid.
REQ-026 Reset after byte 3 -> next cycle o_tvalid=0, cmd_ready=1, no done pulse.
